// File: rtl/abro_pkg.sv
// Shared state encoding for the ABRO "all events seen" controller family.
package abro_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 2'b00,
        ST_COLLECT = 2'b01,
        ST_EMIT    = 2'b10,
        ST_DONE    = 2'b11
    } abro_state_t;

endpackage

// File: rtl/abro_timeout_ctr.sv
// Collection-window counter: synchronous clear beats enable; expired flags count == LIMIT.
module abro_timeout_ctr #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LIM  = W'(LIMIT);
    localparam logic [W-1:0] ZERO = {W{1'b0}};
    localparam logic [W-1:0] ONE  = W'(1);

    logic [W-1:0] count_r;

    // Window count register.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count_r <= ZERO;
        end else if (en) begin
            count_r <= count_r + ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == LIM);

endmodule

// File: rtl/abro_multi_fsm.sv
// N-input ABRO controller: one-cycle strobe once every event line has been seen.
// Optional collection-window timeout is built only when ABRO_TIMEOUT_EN is defined.
module abro_multi_fsm
    import abro_pkg::*;
#(
    parameter int N_INPUTS       = 2,
    parameter int AUTO_RESTART   = 0,
    parameter int COUNT_W        = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                restart,
    input  logic [N_INPUTS-1:0] in_evt,
    output logic                o,
    output logic [STATE_W-1:0]  state,
    output logic [N_INPUTS-1:0] seen,
    output logic [COUNT_W-1:0]  emit_count,
    output logic                timeout
);

    localparam logic [N_INPUTS-1:0] ALL_ONES = {N_INPUTS{1'b1}};
    localparam logic [N_INPUTS-1:0] NONE     = {N_INPUTS{1'b0}};
    localparam logic [COUNT_W-1:0]  CNT_MAX  = {COUNT_W{1'b1}};
    localparam logic [COUNT_W-1:0]  CNT_ZERO = {COUNT_W{1'b0}};
    localparam logic [COUNT_W-1:0]  CNT_ONE  = COUNT_W'(1);

    abro_state_t         state_r;
    abro_state_t         state_nxt_s;
    logic [N_INPUTS-1:0] seen_r;
    logic [N_INPUTS-1:0] seen_nxt_s;
    logic [N_INPUTS-1:0] mask_s;
    logic [COUNT_W-1:0]  count_r;
    logic                o_r;
    logic                timeout_r;
    logic                timeout_nxt_s;
    logic                complete_s;
    logic                expire_s;
    logic                in_collect_s;

    assign mask_s       = seen_r | in_evt;
    assign complete_s   = (mask_s == ALL_ONES);
    assign in_collect_s = (state_r == ST_COLLECT);

`ifdef ABRO_TIMEOUT_EN
    logic tmr_clr_s;

    // Timer runs only while collecting; it restarts from zero on every COLLECT entry.
    assign tmr_clr_s = restart | ~in_collect_s | complete_s | expire_s;

    abro_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk     (clk),
        .reset   (reset),
        .clr     (tmr_clr_s),
        .en      (in_collect_s),
        .expired (expire_s)
    );
`else
    assign expire_s = 1'b0;
`endif

    // Next-state and next-mask decode; restart outranks every transition.
    always_comb begin
        state_nxt_s   = state_r;
        seen_nxt_s    = seen_r;
        timeout_nxt_s = 1'b0;
        if (restart) begin
            state_nxt_s = ST_IDLE;
            seen_nxt_s  = NONE;
        end else begin
            case (state_r)
                ST_IDLE, ST_COLLECT: begin
                    if (complete_s) begin
                        state_nxt_s = ST_EMIT;
                        seen_nxt_s  = ALL_ONES;
                    end else if (expire_s) begin
                        state_nxt_s   = ST_IDLE;
                        seen_nxt_s    = NONE;
                        timeout_nxt_s = 1'b1;
                    end else if (mask_s != NONE) begin
                        state_nxt_s = ST_COLLECT;
                        seen_nxt_s  = mask_s;
                    end else begin
                        state_nxt_s = ST_IDLE;
                        seen_nxt_s  = NONE;
                    end
                end
                ST_EMIT: begin
                    if (AUTO_RESTART != 0) begin
                        state_nxt_s = ST_IDLE;
                        seen_nxt_s  = NONE;
                    end else begin
                        state_nxt_s = ST_DONE;
                        seen_nxt_s  = seen_r;
                    end
                end
                ST_DONE: begin
                    state_nxt_s = ST_DONE;
                    seen_nxt_s  = seen_r;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    seen_nxt_s  = NONE;
                end
            endcase
        end
    end

    // State, mask and registered strobes; o is registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            seen_r    <= NONE;
            o_r       <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            seen_r    <= seen_nxt_s;
            o_r       <= (state_nxt_s == ST_EMIT);
            timeout_r <= timeout_nxt_s;
        end
    end

    // Emission counter bumps on the edge that ends EMIT, unless restart cancels it.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= CNT_ZERO;
        end else if (!restart && (state_r == ST_EMIT) && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign o          = o_r;
    assign state      = state_r;
    assign seen       = seen_r;
    assign emit_count = count_r;
    assign timeout    = timeout_r;

endmodule
